// File: rtl/arm_pkg.sv
// Shared definitions for the pipeline stages.
//   mem_state_t : MEM-stage access FSM state (IDLE, BUSY, DONE)
//   WORD_W      : datapath word width
//   REG_ADDR_W  : register-file address width
//   sat_inc     : saturating 32-bit increment used by the statistics counters
package arm_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with bubble-on-freeze.
//   clk, rst         : clock, asynchronous active-high reset (all fields clear)
//   freeze           : MEM stage is stalled; load a bubble (WB_EN/MEM_R_EN = 0,
//                      other fields hold)
//   ld_en            : a load completes this cycle; capture mem_result_d
//   *_d              : next values from the MEM stage
//   *_q              : registered MEM/WB fields feeding the WB stage
module mem_wb_reg
    import arm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  ld_en,
    input  logic                  wb_en_d,
    input  logic                  mem_r_en_d,
    input  logic [WORD_W-1:0]     alu_result_d,
    input  logic [WORD_W-1:0]     mem_result_d,
    input  logic [REG_ADDR_W-1:0] dest_d,
    output logic                  wb_en_q,
    output logic                  mem_r_en_q,
    output logic [WORD_W-1:0]     alu_result_q,
    output logic [WORD_W-1:0]     mem_result_q,
    output logic [REG_ADDR_W-1:0] dest_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= '0;
            mem_result_q <= '0;
            dest_q       <= '0;
        end else if (freeze) begin
            // Bubble: the held EXE instruction must not write back twice.
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
        end else begin
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            alu_result_q <= alu_result_d;
            dest_q       <= dest_d;
            if (ld_en) begin
                mem_result_q <= mem_result_d;
            end
        end
    end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage with a fixed-latency word-addressed data memory.
//   clk, rst       : clock, asynchronous active-high reset
//   WB_EN_IN       : writeback enable from the EXE register
//   MEM_R_EN_IN    : load request (wins over a simultaneous store)
//   MEM_W_EN_IN    : store request
//   ALU_result_IN  : byte address for loads/stores, passthrough otherwise
//   ST_val_IN      : store data
//   Dest_IN        : destination register
//   freeze         : combinational stall for IF/ID/EXE registers
//   WB_EN, MEM_R_EN, ALU_result, MEM_result, Dest : MEM/WB register outputs
// Optional build macro MEM_STAT_EN adds saturating counters rd_count,
// wr_count and stall_count.
module mem_stage_sram
    import arm_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_EN_IN,
    input  logic                  MEM_R_EN_IN,
    input  logic                  MEM_W_EN_IN,
    input  logic [WORD_W-1:0]     ALU_result_IN,
    input  logic [WORD_W-1:0]     ST_val_IN,
    input  logic [REG_ADDR_W-1:0] Dest_IN,
    output logic                  freeze,
    output logic                  WB_EN,
    output logic                  MEM_R_EN,
    output logic [WORD_W-1:0]     ALU_result,
    output logic [WORD_W-1:0]     MEM_result,
    output logic [REG_ADDR_W-1:0] Dest
`ifdef MEM_STAT_EN
    ,
    output logic [WORD_W-1:0]     rd_count,
    output logic [WORD_W-1:0]     wr_count,
    output logic [WORD_W-1:0]     stall_count
`endif
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? WAIT_CYCLES : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mem_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic mem_op;
    logic is_read;
    logic is_write;
    logic complete;

    logic [WORD_W-1:0] offset;
    logic [WORD_W-1:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic [WORD_W-1:0] rd_data;

    logic [WORD_W-1:0] mem [DEPTH];

    // ---------------------------------------------------------------
    // Request decode and address mapping
    // ---------------------------------------------------------------
    always_comb begin
        mem_op   = MEM_R_EN_IN | MEM_W_EN_IN;
        is_read  = MEM_R_EN_IN;
        is_write = MEM_W_EN_IN & ~MEM_R_EN_IN;

        offset   = ALU_result_IN - WORD_W'(BASE_ADDR);
        word_idx = offset >> 2;
        // The lower bound is checked on the raw address so a wrapped
        // negative offset never aliases into the array.
        in_range = (ALU_result_IN >= WORD_W'(BASE_ADDR)) && (word_idx < DEPTH);
        idx      = word_idx[IDX_W-1:0];
        rd_data  = in_range ? mem[idx] : '0;
    end

    // ---------------------------------------------------------------
    // Access FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Access FSM: next state
    // The IDLE cycle counts as the first stall cycle, so BUSY exits one
    // count early (cnt==1) and a single-cycle wait skips BUSY entirely;
    // this keeps the stall at exactly WAIT_CYCLES for every setting.
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (mem_op && (WAIT_CYCLES > 0)) begin
                    if (WAIT_CYCLES == 1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Access FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        complete = (state == DONE) || ((state == IDLE) && (WAIT_CYCLES == 0));
        // rst forces the stall low at once, since the held inputs would
        // otherwise keep it asserted while the FSM sits in reset.
        freeze   = mem_op & ~complete & ~rst;
    end

    // ---------------------------------------------------------------
    // Data memory (contents not reset)
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && complete && is_write && in_range) begin
            mem[idx] <= ST_val_IN;
        end
    end

    // ---------------------------------------------------------------
    // MEM/WB register
    // ---------------------------------------------------------------
    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .ld_en        (complete & is_read),
        .wb_en_d      (WB_EN_IN),
        .mem_r_en_d   (MEM_R_EN_IN),
        .alu_result_d (ALU_result_IN),
        .mem_result_d (rd_data),
        .dest_d       (Dest_IN),
        .wb_en_q      (WB_EN),
        .mem_r_en_q   (MEM_R_EN),
        .alu_result_q (ALU_result),
        .mem_result_q (MEM_result),
        .dest_q       (Dest)
    );

`ifdef MEM_STAT_EN
    // ---------------------------------------------------------------
    // Saturating access/stall statistics
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count    <= '0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (complete && is_read) begin
                rd_count <= sat_inc(rd_count);
            end
            if (complete && is_write) begin
                wr_count <= sat_inc(wr_count);
            end
            if (freeze) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end
`endif

endmodule
